// File: rtl/uart_packet_pkg.sv
// Shared types and constants for the UART packet parser.
//   state_e : parser FSM states (ST_CHK is reachable only with PACKET_CHECKSUM_EN)
//   hdr_t   : header byte layout {kind[1:0], field[5:0]}
//   HDR_*   : header kind codes; ERR_* : err_code values
package uart_packet_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_B2   = 3'd1,
    ST_B1   = 3'd2,
    ST_B0   = 3'd3,
    ST_CHK  = 3'd4
  } state_e;

  typedef struct packed {
    logic [1:0] kind;
    logic [5:0] field;
  } hdr_t;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CMD  = 2'b10;

  localparam logic [1:0] ERR_IDX  = 2'b01;
  localparam logic [1:0] ERR_FULL = 2'b10;
  localparam logic [1:0] ERR_PKT  = 2'b11;

endpackage

// File: rtl/byte_timeout_counter.sv
// Inter-byte timeout counter for the packet parser.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : forces the count to zero (has priority over enable)
//   enable       : advance the count by one per clock
//   expired      : registered flag, high while the count sits at TIMEOUT_CLKS-1
// The count saturates at TIMEOUT_CLKS-1 and never wraps.
module byte_timeout_counter #(
  parameter int unsigned TIMEOUT_CLKS = 2000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q;

  // Next count: clear wins, otherwise count up until the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == LIMIT);
    end
  end

  assign expired = expired_q;

endmodule

// File: rtl/uart_packet_parser.sv
// Parses the received UART byte stream into DAC words and command codes.
//   clock, reset   : clock and asynchronous active-high reset
//   rx_data        : byte from the UART receiver, valid when rx_byte_ready
//   rx_byte_ready  : 1-cycle byte strobe
//   fifo_data      : 24-bit word shared by all DAC FIFOs, held until the next write
//   fifo_write     : one-hot 1-cycle write strobe, one bit per FIFO
//   fifo_full      : per-FIFO full flags
//   cmd_valid      : 1-cycle strobe, cmd_code valid
//   cmd_code       : command code from header bits [5:0]
//   err_pulse      : 1-cycle strobe on any rejected packet
//   err_code       : 01 bad index, 10 FIFO full, 11 timeout/checksum; held until next error
// Optional build macro PACKET_CHECKSUM_EN adds a 5th XOR checksum byte to DATA packets.
module uart_packet_parser
  import uart_packet_pkg::*;
#(
  parameter int unsigned DACN         = 2,
  parameter int unsigned TIMEOUT_CLKS = 2000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [7:0]      rx_data,
  input  logic            rx_byte_ready,
  output logic [23:0]     fifo_data,
  output logic [DACN-1:0] fifo_write,
  input  logic [DACN-1:0] fifo_full,
  output logic            cmd_valid,
  output logic [5:0]      cmd_code,
  output logic            err_pulse,
  output logic [1:0]      err_code
);

`ifdef PACKET_CHECKSUM_EN
  // All three payload bytes are kept; the word completes on the checksum byte.
  localparam int unsigned SHIFT_W = 24;
`else
  // The last payload byte is taken straight from rx_data.
  localparam int unsigned SHIFT_W = 16;
`endif

  state_e            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [23:0]       fifo_data_q, fifo_data_d;
  logic [DACN-1:0]   fifo_write_q, fifo_write_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [5:0]        cmd_code_q, cmd_code_d;
  logic              err_pulse_q, err_pulse_d;
  logic [1:0]        err_code_q, err_code_d;
`ifdef PACKET_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  hdr_t              hdr_c;
  logic [DACN-1:0]   sel_c;
  logic              idx_bad_c;
  logic              full_hit_c;
  logic              expired_c;

  assign hdr_c      = hdr_t'(rx_data);
  // A shift past the top bit leaves sel_c zero for out-of-range indices.
  assign sel_c      = DACN'(1) << idx_q;
  assign idx_bad_c  = 32'(idx_q) >= DACN;
  assign full_hit_c = |(fifo_full & sel_c);

  // Inter-byte watchdog: runs only while a DATA packet is open.
  byte_timeout_counter #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .clock   (clock),
    .reset   (reset),
    .clear   (rx_byte_ready || (state_q == ST_IDLE)),
    .enable  (state_q != ST_IDLE),
    .expired (expired_c)
  );

  // Next-state and output logic.
  always_comb begin
    logic        finish;
    logic        pkt_bad;
    logic        err_set;
    logic [1:0]  err_val;
    logic [23:0] word;

    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    fifo_data_d  = fifo_data_q;
    fifo_write_d = '0;
    cmd_valid_d  = 1'b0;
    cmd_code_d   = cmd_code_q;
    err_pulse_d  = 1'b0;
    err_code_d   = err_code_q;
`ifdef PACKET_CHECKSUM_EN
    chk_d        = chk_q;
`endif
    finish       = 1'b0;
    pkt_bad      = 1'b0;
    err_set      = 1'b0;
    err_val      = ERR_PKT;
    word         = '0;

    case (state_q)
      ST_IDLE: begin
        if (rx_byte_ready) begin
          case (hdr_c.kind)
            HDR_DATA: begin
              idx_d   = hdr_c.field;
              shift_d = '0;
              state_d = ST_B2;
`ifdef PACKET_CHECKSUM_EN
              chk_d   = rx_data;
`endif
            end
            HDR_CMD: begin
              cmd_valid_d = 1'b1;
              cmd_code_d  = hdr_c.field;
            end
            default: ; // resync filler, dropped silently
          endcase
        end
      end

      ST_B2, ST_B1: begin
        if (rx_byte_ready) begin
          shift_d = {shift_q[SHIFT_W-9:0], rx_data};
          state_d = (state_q == ST_B2) ? ST_B1 : ST_B0;
`ifdef PACKET_CHECKSUM_EN
          chk_d   = chk_q ^ rx_data;
`endif
        end else if (expired_c) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end
      end

      ST_B0: begin
        if (rx_byte_ready) begin
`ifdef PACKET_CHECKSUM_EN
          shift_d = {shift_q[15:0], rx_data};
          chk_d   = chk_q ^ rx_data;
          state_d = ST_CHK;
`else
          finish  = 1'b1;
          word    = {shift_q, rx_data};
          state_d = ST_IDLE;
`endif
        end else if (expired_c) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end
      end

`ifdef PACKET_CHECKSUM_EN
      ST_CHK: begin
        if (rx_byte_ready) begin
          finish  = 1'b1;
          word    = shift_q;
          pkt_bad = (rx_data != chk_q);
          state_d = ST_IDLE;
        end else if (expired_c) begin
          state_d = ST_IDLE;
          err_set = 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // Packet end: checksum, then index, then FIFO-full decide the outcome.
    if (finish) begin
      if (pkt_bad) begin
        err_set = 1'b1;
        err_val = ERR_PKT;
      end else if (idx_bad_c) begin
        err_set = 1'b1;
        err_val = ERR_IDX;
      end else if (full_hit_c) begin
        err_set = 1'b1;
        err_val = ERR_FULL;
      end else begin
        fifo_write_d = sel_c;
        fifo_data_d  = word;
      end
    end

    if (err_set) begin
      err_pulse_d = 1'b1;
      err_code_d  = err_val;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      fifo_data_q  <= '0;
      fifo_write_q <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_code_q   <= '0;
      err_pulse_q  <= 1'b0;
      err_code_q   <= '0;
`ifdef PACKET_CHECKSUM_EN
      chk_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      fifo_data_q  <= fifo_data_d;
      fifo_write_q <= fifo_write_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_code_q   <= cmd_code_d;
      err_pulse_q  <= err_pulse_d;
      err_code_q   <= err_code_d;
`ifdef PACKET_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign fifo_data  = fifo_data_q;
  assign fifo_write = fifo_write_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_code   = cmd_code_q;
  assign err_pulse  = err_pulse_q;
  assign err_code   = err_code_q;

endmodule

// File: tb/tb_uart_packet_parser.sv
// Scoreboard bench for uart_packet_parser: stimulus pushes expected events
// (write / command / error, with the cycle they must appear in) and a monitor
// pops and compares every pulse the DUT emits.
module tb_uart_packet_parser;

  localparam int unsigned DACN = 2;
  localparam int unsigned TO   = 32;
  localparam int K_WR  = 0;
  localparam int K_CMD = 1;
  localparam int K_ERR = 2;

  logic            clk;
  logic            rst;
  logic [7:0]      rx_data;
  logic            rx_byte_ready;
  logic [23:0]     fifo_data;
  logic [DACN-1:0] fifo_write;
  logic [DACN-1:0] fifo_full;
  logic            cmd_valid;
  logic [5:0]      cmd_code;
  logic            err_pulse;
  logic [1:0]      err_code;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int              kind;
    logic [DACN-1:0] wr;
    logic [23:0]     data;
    int              due;
  } exp_t;

  exp_t q[$];

  uart_packet_parser #(
    .DACN(DACN),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clock         (clk),
    .reset         (rst),
    .rx_data       (rx_data),
    .rx_byte_ready (rx_byte_ready),
    .fifo_data     (fifo_data),
    .fifo_write    (fifo_write),
    .fifo_full     (fifo_full),
    .cmd_valid     (cmd_valid),
    .cmd_code      (cmd_code),
    .err_pulse     (err_pulse),
    .err_code      (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    return (k == K_WR) ? "write" : (k == K_CMD) ? "cmd" : "err";
  endfunction

  task automatic push_evt(input int kind, input logic [DACN-1:0] wr,
                          input logic [23:0] data, input int due);
    exp_t e;
    e.kind = kind;
    e.wr   = wr;
    e.data = data;
    e.due  = due;
    q.push_back(e);
  endtask

  // Monitor side: compare one observed pulse with the head of the queue.
  task automatic got(input int kind, input logic [DACN-1:0] wr, input logic [23:0] data);
    exp_t e;
    tests++;
    if (q.size() == 0) begin
      fails++;
      $display("FAIL unexpected %s: got wr=%b data=%h at cyc %0d, required no event",
               kname(kind), wr, data, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.wr != wr || e.data != data || e.due != cyc) begin
        fails++;
        $display("FAIL %s event: got %s wr=%b data=%h cyc=%0d, required %s wr=%b data=%h cyc=%0d",
                 kname(e.kind), kname(kind), wr, data, cyc,
                 kname(e.kind), e.wr, e.data, e.due);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_write != '0) got(K_WR, fifo_write, fifo_data);
      if (cmd_valid)        got(K_CMD, '0, 24'(cmd_code));
      if (err_pulse)        got(K_ERR, '0, 24'(err_code));
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Drive one byte strobe starting this cycle; leaves the strobe high so that
  // consecutive calls produce back-to-back bytes. c = cycle index of the strobe.
  task automatic send_byte(input logic [7:0] b, output int c);
    @(posedge clk);
    #1;
    rx_data       = b;
    rx_byte_ready = 1'b1;
    c             = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      rx_byte_ready = 1'b0;
    end
  endtask

  task automatic send_data(input logic [7:0] h, input logic [23:0] w, output int c);
`ifdef PACKET_CHECKSUM_EN
    logic [7:0] x;
    x = h ^ w[23:16] ^ w[15:8] ^ w[7:0];
`endif
    send_byte(h, c);
    send_byte(w[23:16], c);
    send_byte(w[15:8], c);
    send_byte(w[7:0], c);
`ifdef PACKET_CHECKSUM_EN
    send_byte(x, c);
`endif
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    check({tag, " fifo_write"}, 32'(fifo_write), 32'h0);
    check({tag, " fifo_data"},  32'(fifo_data),  32'h0);
    check({tag, " cmd_valid"},  32'(cmd_valid),  32'h0);
    check({tag, " cmd_code"},   32'(cmd_code),   32'h0);
    check({tag, " err_pulse"},  32'(err_pulse),  32'h0);
    check({tag, " err_code"},   32'(err_code),   32'h0);
  endtask

  initial begin
    int c;
    rst           = 1'b1;
    rx_data       = 8'h00;
    rx_byte_ready = 1'b0;
    fifo_full     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    // Basic write to FIFO0.
    send_data(8'h40, 24'h123456, c);
    push_evt(K_WR, 2'b01, 24'h123456, c + 1);
    idle(3);

    // Command header.
    send_byte(8'h81, c);
    push_evt(K_CMD, '0, 24'h000001, c + 1);
    idle(3);

    // Out-of-range index, then a valid write to FIFO1.
    send_data(8'h45, 24'hAABBCC, c);
    push_evt(K_ERR, '0, 24'(2'b01), c + 1);
    idle(2);
    send_data(8'h41, 24'h000001, c);
    push_evt(K_WR, 2'b10, 24'h000001, c + 1);
    idle(3);

    // FIFO0 full: word dropped, fifo_data keeps the last written word.
    fifo_full = 2'b01;
    send_data(8'h40, 24'hFFFFFF, c);
    push_evt(K_ERR, '0, 24'(2'b10), c + 1);
    idle(3);
    @(negedge clk);
    check("fifo_data held after drop", 32'(fifo_data), 32'h000001);
    check("err_code held", 32'(err_code), 32'h2);
    fifo_full = '0;

    // Filler headers produce nothing.
    send_byte(8'h00, c);
    send_byte(8'hFF, c);
    send_byte(8'h3F, c);
    send_byte(8'hC5, c);
    idle(3);

    // Timeout mid-packet, then a clean packet to FIFO1.
    send_byte(8'h41, c);
    send_byte(8'h12, c);
    push_evt(K_ERR, '0, 24'(2'b11), c + 1 + TO);
    idle(TO + 4);
    send_data(8'h41, 24'hABCDEF, c);
    push_evt(K_WR, 2'b10, 24'hABCDEF, c + 1);
    idle(3);

    // Back-to-back: a command arrives in the write-pulse cycle.
    send_data(8'h40, 24'hAABBCC, c);
    push_evt(K_WR, 2'b01, 24'hAABBCC, c + 1);
    send_byte(8'h82, c);
    push_evt(K_CMD, '0, 24'h000002, c + 1);
    idle(3);

    // Full flag of another channel does not block FIFO0.
    fifo_full = 2'b10;
    send_data(8'h40, 24'h112233, c);
    push_evt(K_WR, 2'b01, 24'h112233, c + 1);
    idle(3);
    fifo_full = '0;

    // Reset mid-packet discards the partial word; parser restarts at a header.
    send_byte(8'h40, c);
    send_byte(8'h12, c);
    send_byte(8'h34, c);
    idle(1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check_reset_state("mid-packet reset");
    send_data(8'h40, 24'h000007, c);
    push_evt(K_WR, 2'b01, 24'h000007, c + 1);
    idle(3);

`ifdef PACKET_CHECKSUM_EN
    // Explicit checksum vectors: 40^01^02^03 = 40.
    send_byte(8'h40, c);
    send_byte(8'h01, c);
    send_byte(8'h02, c);
    send_byte(8'h03, c);
    send_byte(8'h40, c);
    push_evt(K_WR, 2'b01, 24'h010203, c + 1);
    idle(3);
    send_byte(8'h40, c);
    send_byte(8'h01, c);
    send_byte(8'h02, c);
    send_byte(8'h03, c);
    send_byte(8'h00, c);
    push_evt(K_ERR, '0, 24'(2'b11), c + 1);
    idle(3);
`endif

    idle(TO + 5);
    check("scoreboard drained", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
